// File: rtl/button_debouncer_if.sv
// Button bundle between the pins and the debouncer: raw inputs in, clean levels out.
// btn_busy exists only when DEBOUNCE_BUSY_EN is defined.
interface button_debouncer_if #(
    parameter int NUM_BTN = 5
);
    logic [NUM_BTN-1:0] btn_raw;
    logic [NUM_BTN-1:0] btn_db;
`ifdef DEBOUNCE_BUSY_EN
    logic [NUM_BTN-1:0] btn_busy;
`endif

`ifdef DEBOUNCE_BUSY_EN
    modport master (output btn_raw, input btn_db, input btn_busy);
    modport slave  (input btn_raw, output btn_db, output btn_busy);
`else
    modport master (output btn_raw, input btn_db);
    modport slave  (input btn_raw, output btn_db);
`endif
endinterface

// File: rtl/button_debouncer.sv
// Per-button two-flop synchroniser plus STABLE/WAIT debounce FSM, NUM_BTN independent channels.
// Optional macro DEBOUNCE_BUSY_EN adds btn_busy (channel currently qualifying a new level).
module button_debouncer #(
    parameter int NUM_BTN       = 5,
    parameter int STABLE_CYCLES = 1000000
) (
    input  logic              clk,
    input  logic              rst_n,
    button_debouncer_if.slave bus
);
    localparam int CNT_W = $clog2(STABLE_CYCLES + 1);
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(STABLE_CYCLES - 1);
    localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);

    typedef enum logic {
        STABLE = 1'b0,
        WAIT   = 1'b1
    } state_t;

    logic [NUM_BTN-1:0] db_vec;
`ifdef DEBOUNCE_BUSY_EN
    logic [NUM_BTN-1:0] busy_vec;
`endif

    genvar i;
    generate
        for (i = 0; i < NUM_BTN; i++) begin : g_ch
            logic             sync_p0;
            logic             sync_p1;
            state_t           state;
            state_t           state_nxt;
            logic [CNT_W-1:0] count;
            logic [CNT_W-1:0] count_nxt;
            logic             db;
            logic             db_nxt;

            always_ff @(posedge clk or negedge rst_n) begin
                if (!rst_n) begin
                    sync_p0 <= 1'b0;
                    sync_p1 <= 1'b0;
                    state   <= STABLE;
                    count   <= '0;
                    db      <= 1'b0;
                end else begin
                    sync_p0 <= bus.btn_raw[i];
                    sync_p1 <= sync_p0;
                    state   <= state_nxt;
                    count   <= count_nxt;
                    db      <= db_nxt;
                end
            end

            // Any sample that matches the accepted level aborts qualification.
            always_comb begin
                state_nxt = state;
                count_nxt = count;
                db_nxt    = db;
                case (state)
                    STABLE: begin
                        if (sync_p1 != db) begin
                            state_nxt = WAIT;
                            count_nxt = CNT_ONE;
                        end else begin
                            count_nxt = '0;
                        end
                    end
                    WAIT: begin
                        if (sync_p1 == db) begin
                            state_nxt = STABLE;
                            count_nxt = '0;
                        end else if (count == CNT_LAST) begin
                            state_nxt = STABLE;
                            count_nxt = '0;
                            db_nxt    = sync_p1;
                        end else begin
                            count_nxt = count + CNT_ONE;
                        end
                    end
                    default: begin
                        state_nxt = STABLE;
                        count_nxt = '0;
                    end
                endcase
            end

            assign db_vec[i] = db;
`ifdef DEBOUNCE_BUSY_EN
            assign busy_vec[i] = (state == WAIT);
`endif
        end
    endgenerate

    assign bus.btn_db = db_vec;
`ifdef DEBOUNCE_BUSY_EN
    assign bus.btn_busy = busy_vec;
`endif
endmodule

// File: tb/tb_button_debouncer.sv
// Bench for button_debouncer with STABLE_CYCLES=4: vector table through a scoreboard queue,
// plus a hand-written asynchronous reset in the middle of qualification.
module tb_button_debouncer;
    localparam int NB = 5;

    typedef struct {
        logic [NB-1:0] raw;
        logic [NB-1:0] db;
        logic [NB-1:0] busy;
    } vec_t;

    logic clk;
    logic rst_n;
    int   checks;
    int   errors;
    vec_t tbl[$];
    vec_t exp_q[$];

    button_debouncer_if #(.NUM_BTN(NB)) bus ();

    button_debouncer #(
        .NUM_BTN      (NB),
        .STABLE_CYCLES(4)
    ) dut (
        .clk  (clk),
        .rst_n(rst_n),
        .bus  (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish, checks %0d", checks);
        $fatal(1, "watchdog");
    end

    task automatic check(input string name, input int idx, input logic [NB-1:0] act,
                         input logic [NB-1:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s step %0d: got %b want %b", name, idx, act, exp);
        end
    endtask

    task automatic add_n(input logic [NB-1:0] raw, input logic [NB-1:0] db,
                         input logic [NB-1:0] busy, input int n);
        vec_t v;
        v.raw  = raw;
        v.db   = db;
        v.busy = busy;
        for (int k = 0; k < n; k++) tbl.push_back(v);
    endtask

    // Called at a falling edge: drive, let one rising edge pass, compare at the next falling edge.
    task automatic step(input vec_t v, input int idx);
        vec_t e;
        exp_q.push_back(v);
        bus.btn_raw = v.raw;
        @(posedge clk);
        @(negedge clk);
        e = exp_q.pop_front();
        check("btn_db", idx, bus.btn_db, e.db);
`ifdef DEBOUNCE_BUSY_EN
        check("btn_busy", idx, bus.btn_busy, e.busy);
`endif
    endtask

    task automatic step_v(input logic [NB-1:0] raw, input logic [NB-1:0] db,
                          input logic [NB-1:0] busy, input int idx);
        vec_t v;
        v.raw  = raw;
        v.db   = db;
        v.busy = busy;
        step(v, idx);
    endtask

    initial begin
        checks = 0;
        errors = 0;
        rst_n = 1'b0;
        bus.btn_raw = '0;

        // Clean press on channel 0, then release.
        add_n(5'h01, 5'h00, 5'h00, 2);
        add_n(5'h01, 5'h00, 5'h01, 3);
        add_n(5'h01, 5'h01, 5'h00, 2);
        add_n(5'h00, 5'h01, 5'h00, 2);
        add_n(5'h00, 5'h01, 5'h01, 3);
        add_n(5'h00, 5'h00, 5'h00, 2);
        // Channel 2 bounce 1,1,0,1,1,0 then held 1.
        add_n(5'h04, 5'h00, 5'h00, 2);
        add_n(5'h00, 5'h00, 5'h04, 1);
        add_n(5'h04, 5'h00, 5'h04, 1);
        add_n(5'h04, 5'h00, 5'h00, 1);
        add_n(5'h00, 5'h00, 5'h04, 1);
        add_n(5'h04, 5'h00, 5'h04, 1);
        add_n(5'h04, 5'h00, 5'h00, 1);
        add_n(5'h04, 5'h00, 5'h04, 3);
        add_n(5'h04, 5'h04, 5'h00, 2);
        add_n(5'h00, 5'h04, 5'h00, 2);
        add_n(5'h00, 5'h04, 5'h04, 3);
        add_n(5'h00, 5'h00, 5'h00, 2);
        // Channel 1 press, 3-cycle release glitch, then real release.
        add_n(5'h02, 5'h00, 5'h00, 2);
        add_n(5'h02, 5'h00, 5'h02, 3);
        add_n(5'h02, 5'h02, 5'h00, 2);
        add_n(5'h00, 5'h02, 5'h00, 2);
        add_n(5'h00, 5'h02, 5'h02, 1);
        add_n(5'h02, 5'h02, 5'h02, 2);
        add_n(5'h02, 5'h02, 5'h00, 3);
        add_n(5'h00, 5'h02, 5'h00, 2);
        add_n(5'h00, 5'h02, 5'h02, 3);
        add_n(5'h00, 5'h00, 5'h00, 2);
        // Channels 3 and 4 together, channel 4 bounces at cycle 2.
        add_n(5'h18, 5'h00, 5'h00, 2);
        add_n(5'h08, 5'h00, 5'h18, 1);
        add_n(5'h18, 5'h00, 5'h18, 1);
        add_n(5'h18, 5'h00, 5'h08, 1);
        add_n(5'h18, 5'h08, 5'h10, 3);
        add_n(5'h18, 5'h18, 5'h00, 2);
        add_n(5'h00, 5'h18, 5'h00, 2);
        add_n(5'h00, 5'h18, 5'h18, 3);
        add_n(5'h00, 5'h00, 5'h00, 2);
        // Channel 3 settled high, channel 0 two cycles into WAIT.
        add_n(5'h08, 5'h00, 5'h00, 2);
        add_n(5'h08, 5'h00, 5'h08, 3);
        add_n(5'h08, 5'h08, 5'h00, 2);
        add_n(5'h09, 5'h08, 5'h00, 2);
        add_n(5'h09, 5'h08, 5'h01, 2);

        repeat (2) @(negedge clk);
        check("reset_db", -1, bus.btn_db, 5'h00);
`ifdef DEBOUNCE_BUSY_EN
        check("reset_busy", -1, bus.btn_busy, 5'h00);
`endif
        rst_n = 1'b1;

        for (int i = 0; i < tbl.size(); i++) step(tbl[i], i);

        // Asynchronous reset between edges while channel 0 is mid-qualification.
        #2 rst_n = 1'b0;
        #1 check("async_rst_db", 1000, bus.btn_db, 5'h00);
`ifdef DEBOUNCE_BUSY_EN
        check("async_rst_busy", 1000, bus.btn_busy, 5'h00);
`endif
        @(posedge clk);
        @(negedge clk);
        check("held_rst_db", 1001, bus.btn_db, 5'h00);
        rst_n = 1'b1;
        for (int k = 0; k < 2; k++) step_v(5'h09, 5'h00, 5'h00, 1100 + k);
        for (int k = 2; k < 5; k++) step_v(5'h09, 5'h00, 5'h09, 1100 + k);
        for (int k = 5; k < 7; k++) step_v(5'h09, 5'h09, 5'h00, 1100 + k);

        if (exp_q.size() != 0) begin
            errors++;
            $display("FAIL scoreboard: %0d entries left, want 0", exp_q.size());
        end
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
